pipe_skid_buffer: RTL and testbench

//   Two-entry valid/ready pipeline register for the 5-stage core. Sits between
//   a producing stage (s_*) and a consuming stage (m_*). Breaks the

---
 rtl/pipe_skid_buffer.sv | 86 ++++++++
 tb/tb_pipe_skid_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready pipeline register. The main entry drives m_data; the
// skid entry catches one beat when the consumer stalls. All outputs are registered.
module pipe_skid_buffer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_xfer;
  logic             out_xfer;

  // Handshake flags come straight from the state register, so neither
  // m_ready nor s_valid has a combinational path to an output.
  assign m_valid = (state_q != EMPTY);
  assign s_ready = (state_q != FULL);
  assign m_data  = main_q;

  assign in_xfer  = s_valid & s_ready;
  assign out_xfer = m_valid & m_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Flush drops the valids only; the payload registers keep their contents.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_d  = s_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (in_xfer && out_xfer) begin
            main_d = s_data;
          end else if (in_xfer) begin
            skid_d  = s_data;
            state_d = FULL;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = BUSY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Self-checking bench for pipe_skid_buffer: a FIFO model of the held beats is
// compared every cycle, plus directed checks with literal expected values.
module tb_pipe_skid_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];

  pipe_skid_buffer #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the buffer is an ordered queue of at most two beats.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      bit take_in, take_out;
      take_in  = s_valid && (q.size() < 2);
      take_out = m_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
        if (take_out) void'(q.pop_front());
        if (take_in) q.push_back(s_data);
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (m_valid !== (q.size() > 0)) begin
      errors++;
      $display("FAIL model_m_valid t=%0t actual=%0b required=%0b", $time, m_valid, q.size() > 0);
    end
    checks++;
    if (s_ready !== (q.size() < 2)) begin
      errors++;
      $display("FAIL model_s_ready t=%0t actual=%0b required=%0b", $time, s_ready, q.size() < 2);
    end
    if (q.size() > 0) begin
      checks++;
      if (m_data !== q[0]) begin
        errors++;
        $display("FAIL model_m_data t=%0t actual=%h required=%h", $time, m_data, q[0]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end else begin
      $display("ok   %s t=%0t value=%h", name, $time, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic v, input logic r, input logic [31:0] d, input bit chk_d);
    check({name, ".m_valid"}, {31'd0, m_valid}, {31'd0, v});
    check({name, ".s_ready"}, {31'd0, s_ready}, {31'd0, r});
    if (chk_d) check({name, ".m_data"}, m_data, d);
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: idle after reset
    expect_out("reset_idle", 1'b0, 1'b1, 32'h0, 1'b1);

    // 2: back-to-back stream with consumer always ready
    m_ready = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h11;
    step();
    expect_out("stream_11", 1'b1, 1'b1, 32'h11, 1'b1);
    s_data = 32'h22;
    step();
    expect_out("stream_22", 1'b1, 1'b1, 32'h22, 1'b1);
    s_data = 32'h33;
    step();
    expect_out("stream_33", 1'b1, 1'b1, 32'h33, 1'b1);
    s_valid = 1'b0;
    step();
    expect_out("stream_drain", 1'b0, 1'b1, 32'h0, 1'b0);

    // 3: stall fills both entries
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hA0;
    step();
    expect_out("stall_a0", 1'b1, 1'b1, 32'hA0, 1'b1);
    s_data = 32'hB0;
    step();
    expect_out("stall_full", 1'b1, 1'b0, 32'hA0, 1'b1);

    // 4: offers while full are refused and held data is stable
    s_data = 32'hCC;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("full_hold%0d", i), 1'b1, 1'b0, 32'hA0, 1'b1);
    end
    s_valid = 1'b0;

    m_ready = 1'b1;
    step();
    expect_out("release_b0", 1'b1, 1'b1, 32'hB0, 1'b1);
    step();
    expect_out("release_empty", 1'b0, 1'b1, 32'h0, 1'b0);

    // 5: flush while full
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'hA0;
    step();
    s_data = 32'hB0;
    step();
    expect_out("refill_full", 1'b1, 1'b0, 32'hA0, 1'b1);
    s_valid = 1'b0;
    flush   = 1'b1;
    m_ready = 1'b1;
    step();
    flush = 1'b0;
    expect_out("flush_empty", 1'b0, 1'b1, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      expect_out($sformatf("flush_stay%0d", i), 1'b0, 1'b1, 32'h0, 1'b0);
    end

    // 6: asynchronous reset between edges
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 32'h01;
    step();
    s_data = 32'h02;
    step();
    expect_out("pre_rst_full", 1'b1, 1'b0, 32'h01, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 1'b1, 32'h0, 1'b1);
    s_valid = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    s_valid = 1'b1;
    s_data  = 32'h5A;
    m_ready = 1'b1;
    step();
    expect_out("post_rst_5a", 1'b1, 1'b1, 32'h5A, 1'b1);
    s_valid = 1'b0;
    step();
    expect_out("post_rst_drain", 1'b0, 1'b1, 32'h0, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
